// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver.
// Parity support is selected at build time with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Even parity: XOR of the data bits and the parity bit must be 0.
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle level (1).
module rx_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // Next values: plain two-stage shift.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Synchronizer flops, idle-high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 serial byte receiver feeding the hex display stage.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a parityError strobe.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       update,
  output logic       frameError,
  output logic       parityError
);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_synchronizer u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 update_q, update_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  // Next-state, sampling and strobe generation; strobes are registered so they
  // appear the cycle after the stop-bit sample, when the FSM is already in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    update_d = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == BIT_M1) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = S_STOP;
        end
`else
        cnt_d   = '0;
        state_d = S_IDLE;
`endif
      end

      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              update_d = 1'b1;
              data_d   = shift_q;
            end
`else
            update_d = 1'b1;
            data_d   = shift_q;
`endif
            state_d = S_IDLE;
          end else begin
            // Bad stop bit wins over any parity result.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      update_q <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      update_q <= update_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data       = data_q;
  assign update     = update_q;
  assign frameError = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parityError = perr_q;
`else
  assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver at 16 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_byte_receiver;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit          PAR_EN     = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit          PAR_EN     = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Pin start edge -> strobe: 2 synchronizer cycles + half bit + data (+parity)
  // + stop bit periods + 1 register cycle.
  localparam int unsigned LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  typedef enum int {EV_UPD, EV_FERR, EV_PERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  d;
    int unsigned cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       update, frameError, parityError;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  model_data = 8'h00;
  logic        prev_upd = 1'b0;
  ev_t         exp_q[$];
  ev_t         got_q[$];

  uart_byte_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data        (data),
    .update      (update),
    .frameError  (frameError),
    .parityError (parityError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs every strobe and checks exclusivity and pulse width.
  always @(negedge clk) begin
    if (rst_n) begin
      if (update | frameError | parityError) begin
        ev_t e;
        checks++;
        if ($countones({update, frameError, parityError}) > 1) begin
          errors++;
          $display("FAIL strobe_exclusive: upd=%b ferr=%b perr=%b want at most one", update, frameError, parityError);
        end
        e.kind = update ? EV_UPD : (frameError ? EV_FERR : EV_PERR);
        e.d    = data;
        e.cyc  = cyc;
        got_q.push_back(e);
      end
      if (update && prev_upd) begin
        checks++;
        errors++;
        $display("FAIL update_width: update high two cycles in a row at cycle %0d", cyc);
      end
      prev_upd = update;
    end else begin
      prev_upd = 1'b0;
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and records the outcome the line protocol implies.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    logic [FRAME_BITS-1:0] v;
    ev_t e;
`ifdef UART_RX_PARITY_EN
    v = {stop_ok, (^b) ^ ~par_ok, b, 1'b0};
`else
    v = {stop_ok, b, 1'b0};
`endif
    e.cyc = cyc + LAT;
    if (!stop_ok)              e.kind = EV_FERR;
    else if (PAR_EN && !par_ok) e.kind = EV_PERR;
    else begin
      e.kind     = EV_UPD;
      model_data = b;
    end
    e.d = model_data;
    exp_q.push_back(e);
    for (int i = 0; i < FRAME_BITS; i++) begin
      rx = v[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({data, update, frameError, parityError} !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs: data=%h upd=%b ferr=%b perr=%b want 00/0/0/0", data, update, frameError, parityError);
    end
    rst_n = 1'b1;
    idle(30);
    checks++;
    if (got_q.size() != 0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle: strobes=%0d data=%h want 0 strobes, data 00", got_q.size(), data);
    end
  endtask

  task automatic test_single_frame;
    exp_q.delete(); got_q.delete();
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL single_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
    checks++;
    if (data !== 8'hA5) begin
      errors++;
      $display("FAIL single_data_hold: data=%h want a5", data);
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete(); got_q.delete();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL b2b_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_glitch;
    exp_q.delete(); got_q.delete();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    checks++;
    if (got_q.size() != 0 || data !== model_data) begin
      errors++;
      $display("FAIL glitch_ignored: strobes=%0d data=%h want 0 strobes, data %h", got_q.size(), data, model_data);
    end
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL glitch_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL glitch_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_break;
    exp_q.delete(); got_q.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    idle(30);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL break_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL break_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] v;
    exp_q.delete(); got_q.delete();
    v = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = v[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = v[5];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data, update, frameError, parityError} !== 11'h000) begin
      errors++;
      $display("FAIL midreset_async: data=%h upd=%b ferr=%b perr=%b want 00/0/0/0", data, update, frameError, parityError);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    model_data = 8'h00;
    idle(20);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_nostrobe: got %0d strobes want 0", got_q.size());
    end
    exp_q.delete();
    send_frame(8'h6B, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != 1 || got_q[0].kind != EV_UPD || got_q[0].d !== 8'h6B || got_q[0].cyc != exp_q[0].cyc) begin
      errors++;
      $display("FAIL midreset_recover: strobes=%0d data=%h want 1 update with data 6b at cycle %0d", got_q.size(), data, exp_q[0].cyc);
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    bit stop_ok, par_ok;
    exp_q.delete(); got_q.delete();
    for (int n = 0; n < 16; n++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(3) != 0);
      par_ok  = ($urandom_range(3) != 0);
      send_frame(b, stop_ok, par_ok);
      if (!stop_ok) idle(20);
      else          idle($urandom_range(20));
    end
    idle(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d strobes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL random_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    exp_q.delete(); got_q.delete();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL parity_count: got %0d strobes want 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].kind != exp_q[i].kind || got_q[i].d !== exp_q[i].d || got_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL parity_ev%0d: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", i,
                 got_q[i].kind, got_q[i].d, got_q[i].cyc, exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid_frame;
    test_random;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
